// File: rtl/y86_phase_sequencer.sv
// Run-control sequencer for the 5-phase multicycle y86 core: one-hot phase strobes,
// run/stop/step/halt control and bus watchdog. Optional perf counters: Y86_SEQ_PERF_CNT_EN.
module y86_phase_sequencer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             step_req,
  input  logic             clr_halt,
  input  logic             halt_op,
  input  logic             ls_op,
  input  logic             mem_ready,
  output logic [4:0]       phase,
  output logic             mem_req,
  output logic             running,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit WD_EN  = (WAIT_MAX > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
  localparam logic [4:0] PTR_FETCH = 5'b00001;

  state_e             state_q, state_d;
  logic [4:0]         ptr_q, ptr_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   instr_q, instr_d;

  logic               running_s;
  logic               mem_cycle_s;
  logic               mem_req_s;
  logic               stall_s;
  logic               adv_s;
  logic               timeout_s;
  logic [4:0]         phase_s;

  // Strobe generation: a memory phase only advances once mem_ready is seen.
  always_comb begin
    running_s   = (state_q == ST_RUN) || (state_q == ST_STEP);
    mem_cycle_s = ptr_q[0] | (ptr_q[3] & ls_op);
    mem_req_s   = running_s & mem_cycle_s;
    stall_s     = mem_req_s & ~mem_ready;
    adv_s       = running_s & (~mem_cycle_s | mem_ready);
    timeout_s   = WD_EN && stall_s && (wait_q == WAIT_LAST);
    if (adv_s) begin
      phase_s = ptr_q;
    end else begin
      phase_s = 5'b00000;
    end
  end

  // Next-state: run control, halt capture, watchdog and retire counter.
  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    if (adv_s) begin
      ptr_d = {ptr_q[3:0], ptr_q[4]};
    end else begin
      ptr_d = ptr_q;
    end
    if (stall_s) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = {WAIT_W{1'b0}};
    end
    if (phase_s[4]) begin
      instr_d = instr_q + CNT_W'(1);
    end else begin
      instr_d = instr_q;
    end

    case (state_q)
      ST_STOP: begin
        if (run_en) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (phase_s[1] && halt_op) begin
          state_d = ST_HALTED;
          ptr_d   = PTR_FETCH;
        end else if (phase_s[4] && !run_en) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (phase_s[1] && halt_op) begin
          state_d = ST_HALTED;
          ptr_d   = PTR_FETCH;
        end else if (phase_s[4]) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_STEP;
        end
      end
      ST_HALTED: begin
        if (clr_halt) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_STOP;
        ptr_d   = PTR_FETCH;
      end
    endcase

    // A bus timeout abandons the instruction regardless of run state.
    if (timeout_s) begin
      state_d   = ST_HALTED;
      ptr_d     = PTR_FETCH;
      bus_err_d = 1'b1;
      wait_d    = {WAIT_W{1'b0}};
    end else begin
      bus_err_d = bus_err_d;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOP;
      ptr_q     <= PTR_FETCH;
      wait_q    <= {WAIT_W{1'b0}};
      bus_err_q <= 1'b0;
      instr_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      instr_q   <= instr_d;
    end
  end

  assign phase       = phase_s;
  assign mem_req     = mem_req_s;
  assign running     = running_s;
  assign halted      = (state_q == ST_HALTED);
  assign bus_err     = bus_err_q;
  assign instr_count = instr_q;

`ifdef Y86_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  // Performance counter increments.
  always_comb begin
    if (running_s) begin
      cycle_d = cycle_q + CNT_W'(1);
    end else begin
      cycle_d = cycle_q;
    end
    if (stall_s) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= {CNT_W{1'b0}};
      stall_q <= {CNT_W{1'b0}};
    end else begin
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  assign cycle_count = cycle_q;
  assign stall_count = stall_q;
`else
  assign cycle_count = {CNT_W{1'b0}};
  assign stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_y86_phase_sequencer.sv
// Directed self-checking bench for y86_phase_sequencer (WAIT_MAX=16, CNT_W=32).
module tb_y86_phase_sequencer;

  logic        clk;
  logic        rst;
  logic        run_en;
  logic        step_req;
  logic        clr_halt;
  logic        halt_op;
  logic        ls_op;
  logic        mem_ready;
  logic [4:0]  phase;
  logic        mem_req;
  logic        running;
  logic        halted;
  logic        bus_err;
  logic [31:0] instr_count;
  logic [31:0] cycle_count;
  logic [31:0] stall_count;

  int total;
  int bad;

  y86_phase_sequencer #(.WAIT_MAX(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .step_req(step_req),
    .clr_halt(clr_halt), .halt_op(halt_op), .ls_op(ls_op), .mem_ready(mem_ready),
    .phase(phase), .mem_req(mem_req), .running(running), .halted(halted),
    .bus_err(bus_err), .instr_count(instr_count), .cycle_count(cycle_count),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef Y86_SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic test_reset();
    rst = 1'b1; run_en = 1'b0; step_req = 1'b0; clr_halt = 1'b0;
    halt_op = 1'b0; ls_op = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({phase, mem_req, running, halted, bus_err} !== 9'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 000000000", {phase, mem_req, running, halted, bus_err});
    end
    total++;
    if (instr_count !== 32'd0 || cycle_count !== 32'd0 || stall_count !== 32'd0) begin
      bad++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", instr_count, cycle_count, stall_count);
    end
  endtask

  task automatic test_run();
    logic [4:0] one;
    logic [4:0] exp_ph;
    one = 5'b00001;
    @(negedge clk); run_en = 1'b1; #1;
    total++;
    if (phase !== 5'b00000) begin
      bad++; $display("FAIL run_stop_cycle: got %b want 00000", phase);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 14) run_en = 1'b0;
      #1;
      exp_ph = one << (i % 5);
      total++;
      if (phase !== exp_ph || running !== 1'b1) begin
        bad++; $display("FAIL run_phase[%0d]: got %b run=%b want %b run=1", i, phase, running, exp_ph);
      end
    end
    @(negedge clk); #1;
    total++;
    if (running !== 1'b0 || phase !== 5'b00000 || instr_count !== 32'd3) begin
      bad++; $display("FAIL run_stop: got run=%b ph=%b ic=%0d want 0 00000 3", running, phase, instr_count);
    end
    total++;
    if (cycle_count !== (PERF ? 32'd15 : 32'd0)) begin
      bad++; $display("FAIL run_cycle_count: got %0d want %0d", cycle_count, PERF ? 15 : 0);
    end
  endtask

  task automatic test_fetch_stall();
    logic [4:0] one;
    one = 5'b00001;
    @(negedge clk); run_en = 1'b1; mem_ready = 1'b0; #1;
    total++;
    if (mem_req !== 1'b0) begin
      bad++; $display("FAIL stall_idle_req: got %b want 0", mem_req);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (phase !== 5'b00000 || mem_req !== 1'b1) begin
        bad++; $display("FAIL stall_wait[%0d]: got ph=%b req=%b want 00000 1", i, phase, mem_req);
      end
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    total++;
    if (phase !== 5'b00001 || mem_req !== 1'b1) begin
      bad++; $display("FAIL stall_release: got ph=%b req=%b want 00001 1", phase, mem_req);
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) run_en = 1'b0;
      #1;
      total++;
      if (phase !== (one << i)) begin
        bad++; $display("FAIL stall_phase[%0d]: got %b want %b", i, phase, one << i);
      end
    end
    @(negedge clk); #1;
    total++;
    if (running !== 1'b0 || instr_count !== 32'd4) begin
      bad++; $display("FAIL stall_end: got run=%b ic=%0d want 0 4", running, instr_count);
    end
    total++;
    if (stall_count !== (PERF ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL stall_count: got %0d want %0d", stall_count, PERF ? 3 : 0);
    end
  endtask

  task automatic test_ls_op();
    logic [4:0] ph_t  [0:6];
    logic       rdy_t [0:6];
    logic       req_t [0:6];
    ph_t  = '{5'b00001, 5'b00010, 5'b00100, 5'b00000, 5'b00000, 5'b01000, 5'b10000};
    rdy_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    req_t = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk); run_en = 1'b1; ls_op = 1'b1; mem_ready = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      mem_ready = rdy_t[i];
      if (i == 6) run_en = 1'b0;
      #1;
      total++;
      if (phase !== ph_t[i] || mem_req !== req_t[i]) begin
        bad++; $display("FAIL ls_cycle[%0d]: got ph=%b req=%b want %b %b", i, phase, mem_req, ph_t[i], req_t[i]);
      end
    end
    @(negedge clk); ls_op = 1'b0; #1;
    total++;
    if (running !== 1'b0 || instr_count !== 32'd5 || stall_count !== (PERF ? 32'd5 : 32'd0)) begin
      bad++; $display("FAIL ls_end: got run=%b ic=%0d sc=%0d want 0 5 %0d", running, instr_count, stall_count, PERF ? 5 : 0);
    end
  endtask

  task automatic test_step();
    logic [4:0] one;
    one = 5'b00001;
    @(negedge clk); step_req = 1'b1; #1;
    total++;
    if (phase !== 5'b00000) begin
      bad++; $display("FAIL step_req_cycle: got %b want 00000", phase);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); step_req = (i == 2); #1;
      total++;
      if (phase !== (one << i) || running !== 1'b1) begin
        bad++; $display("FAIL step_phase[%0d]: got ph=%b run=%b want %b 1", i, phase, running, one << i);
      end
    end
    @(negedge clk); step_req = 1'b0; #1;
    total++;
    if (running !== 1'b0 || phase !== 5'b00000 || instr_count !== 32'd6) begin
      bad++; $display("FAIL step_end: got run=%b ph=%b ic=%0d want 0 00000 6", running, phase, instr_count);
    end
    @(negedge clk); #1;
    total++;
    if (running !== 1'b0 || phase !== 5'b00000) begin
      bad++; $display("FAIL step_stays_stopped: got run=%b ph=%b want 0 00000", running, phase);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] one;
    one = 5'b00001;
    @(negedge clk); run_en = 1'b1; step_req = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      step_req = (i == 3);
      if (i == 9) run_en = 1'b0;
      #1;
      total++;
      if (phase !== (one << (i % 5))) begin
        bad++; $display("FAIL b2b_phase[%0d]: got %b want %b", i, phase, one << (i % 5));
      end
    end
    @(negedge clk); step_req = 1'b0; #1;
    total++;
    if (running !== 1'b0 || instr_count !== 32'd8) begin
      bad++; $display("FAIL b2b_end: got run=%b ic=%0d want 0 8", running, instr_count);
    end
  endtask

  task automatic test_halt();
    logic [4:0] one;
    one = 5'b00001;
    @(negedge clk); run_en = 1'b1; halt_op = 1'b1; #1;
    @(negedge clk); #1;
    total++;
    if (phase !== 5'b00001) begin
      bad++; $display("FAIL halt_fetch: got %b want 00001", phase);
    end
    @(negedge clk); #1;
    total++;
    if (phase !== 5'b00010) begin
      bad++; $display("FAIL halt_decode: got %b want 00010", phase);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (halted !== 1'b1 || phase !== 5'b00000 || running !== 1'b0) begin
        bad++; $display("FAIL halt_hold[%0d]: got h=%b ph=%b run=%b want 1 00000 0", i, halted, phase, running);
      end
    end
    total++;
    if (instr_count !== 32'd8) begin
      bad++; $display("FAIL halt_icount: got %0d want 8", instr_count);
    end
    @(negedge clk); run_en = 1'b0; halt_op = 1'b0; clr_halt = 1'b1; #1;
    @(negedge clk); clr_halt = 1'b0; #1;
    total++;
    if (halted !== 1'b0 || running !== 1'b0) begin
      bad++; $display("FAIL halt_clear: got h=%b run=%b want 0 0", halted, running);
    end
    @(negedge clk); run_en = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) run_en = 1'b0;
      #1;
      total++;
      if (phase !== (one << i)) begin
        bad++; $display("FAIL halt_resume[%0d]: got %b want %b", i, phase, one << i);
      end
    end
    @(negedge clk); #1;
    total++;
    if (instr_count !== 32'd9 || running !== 1'b0) begin
      bad++; $display("FAIL halt_resume_end: got ic=%0d run=%b want 9 0", instr_count, running);
    end
  endtask

  task automatic test_watchdog();
    @(negedge clk); run_en = 1'b1; mem_ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      total++;
      if (phase !== 5'b00000 || mem_req !== 1'b1 || halted !== 1'b0 || bus_err !== 1'b0) begin
        bad++; $display("FAIL wd_wait[%0d]: got ph=%b req=%b h=%b be=%b want 00000 1 0 0", i, phase, mem_req, halted, bus_err);
      end
    end
    @(negedge clk); #1;
    total++;
    if (halted !== 1'b1 || bus_err !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL wd_timeout: got h=%b be=%b req=%b want 1 1 0", halted, bus_err, mem_req);
    end
    @(negedge clk); run_en = 1'b0; mem_ready = 1'b1; clr_halt = 1'b1; #1;
    @(negedge clk); clr_halt = 1'b0; #1;
    total++;
    if (halted !== 1'b0 || bus_err !== 1'b1) begin
      bad++; $display("FAIL wd_clr_sticky: got h=%b be=%b want 0 1", halted, bus_err);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); run_en = 1'b1; #1;
    @(negedge clk); #1;
    total++;
    if (phase !== 5'b00001) begin
      bad++; $display("FAIL ar_fetch: got %b want 00001", phase);
    end
    @(negedge clk); #1;
    total++;
    if (phase !== 5'b00010) begin
      bad++; $display("FAIL ar_decode: got %b want 00010", phase);
    end
    rst = 1'b1; #1;
    total++;
    if (phase !== 5'b00000 || running !== 1'b0 || bus_err !== 1'b0 || instr_count !== 32'd0) begin
      bad++; $display("FAIL ar_abort: got ph=%b run=%b be=%b ic=%0d want 00000 0 0 0", phase, running, bus_err, instr_count);
    end
    @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); #1;
    total++;
    if (phase !== 5'b00001) begin
      bad++; $display("FAIL ar_restart: got %b want 00001", phase);
    end
    run_en = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_run();
    test_fetch_stall();
    test_ls_op();
    test_step();
    test_back_to_back();
    test_halt();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
